// File: rtl/flow_unload.sv
// Parallel-in, serial-out unloader: takes one (NUM+1)*WIDTH vector and emits it
// highest lane first. Define FLOW_UNLOAD_B2B_EN to accept the next vector on the final beat.
module flow_unload #(
  parameter int NUM   = 0,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [(NUM+1)*WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0]       fill,
  output logic [WIDTH-1:0]       out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int TW = (NUM + 1) * WIDTH;
  localparam int CW = (NUM == 0) ? 1 : $clog2(NUM + 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // out_valid stays high and out holds until that transfer, load_ready never looks at load_valid.

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t          state, state_d;
  logic [TW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [TW-1:0]   shifted;

  generate
    if (NUM > 0) begin : g_shift
      assign shifted = {data_q[TW-WIDTH-1:0], fill};
    end else begin : g_single
      assign shifted = fill;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      data_q <= data_d;
      cnt    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    data_d     = data_q;
    cnt_d      = cnt;
    load_ready = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          data_d  = load_data;
          cnt_d   = CW'(NUM);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
`ifdef FLOW_UNLOAD_B2B_EN
        load_ready = out_ready && (cnt == '0);
`else
        load_ready = 1'b0;
`endif
        if (out_ready) begin
          if (cnt != '0) begin
            data_d = shifted;
            cnt_d  = cnt - CW'(1);
          end else begin
            state_d = IDLE;
`ifdef FLOW_UNLOAD_B2B_EN
            // Reload on the final-beat handshake so the next vector follows without a bubble.
            if (load_valid) begin
              data_d  = load_data;
              cnt_d   = CW'(NUM);
              state_d = SHIFT;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out       = data_q[TW-1 -: WIDTH];
  assign out_valid = (state == SHIFT);
  assign out_last  = (state == SHIFT) && (cnt == '0);

endmodule

// File: tb/tb_flow_unload.sv
// Directed-vector bench for flow_unload (NUM=3 and NUM=0 instances), with a
// shift-register collector rebuilding the vector from accepted beats.
module tb_flow_unload;

`ifdef FLOW_UNLOAD_B2B_EN
  localparam logic B2B = 1'b1;
`else
  localparam logic B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // NUM=3 instance
  logic        lv, lr, ov, orr, last;
  logic [31:0] ld;
  logic [7:0]  fill, out;

  flow_unload #(.NUM(3), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(lr), .load_data(ld),
    .fill(fill), .out(out), .out_valid(ov), .out_ready(orr), .out_last(last)
  );

  // NUM=0 instance
  logic       lv0, lr0, ov0, or0, last0;
  logic [7:0] ld0, out0;

  flow_unload #(.NUM(0), .WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
    .fill(fill), .out(out0), .out_valid(ov0), .out_ready(or0), .out_last(last0)
  );

  // Collector: a flow-style shift register enabled on every accepted beat.
  logic [31:0] y = '0;
  int          beats = 0;
  always @(posedge clk) begin
    if (ov && orr) begin
      y     <= {y[23:0], out};
      beats <= beats + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        lv;
    logic [31:0] ld;
    logic        orr;
    logic        ev;
    logic [7:0]  eo;
    logic        el;
    logic        elr;
    logic        co;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic v, logic [31:0] d, logic o,
                              logic ev, logic [7:0] eo, logic el, logic elr, logic co);
    vec_t t;
    t.rst = r; t.lv = v; t.ld = d; t.orr = o;
    t.ev = ev; t.eo = eo; t.el = el; t.elr = elr; t.co = co;
    tbl.push_back(t);
  endfunction

  function automatic void idle(logic v, logic [31:0] d);
    add(1'b0, v, d, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic void beat(logic v, logic [31:0] d, logic o, logic [7:0] eo,
                               logic el, logic elr);
    add(1'b0, v, d, o, 1'b1, eo, el, elr, 1'b1);
  endfunction

  function automatic void build_table();
    // reset state
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    // basic order; the 0x99999999 load is offered while busy and must be ignored
    idle(1'b1, 32'h44332211);
    beat(1'b0, 32'h0, 1'b1, 8'h44, 1'b0, 1'b0);
    beat(1'b1, 32'h99999999, 1'b1, 8'h33, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h22, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h11, 1'b1, B2B);
    idle(1'b0, 32'h0);
    // backpressure on 0x33 for two cycles
    idle(1'b1, 32'h44332211);
    beat(1'b0, 32'h0, 1'b1, 8'h44, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b0, 8'h33, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b0, 8'h33, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h33, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h22, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h11, 1'b1, B2B);
    idle(1'b0, 32'h0);
    // reset mid-vector, then a fresh load of 7
    idle(1'b1, 32'h44332211);
    beat(1'b0, 32'h0, 1'b1, 8'h44, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h33, 1'b0, 1'b0);
    add(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h00000007, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    beat(1'b0, 32'h0, 1'b1, 8'h00, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h00, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h00, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h07, 1'b1, B2B);
    idle(1'b0, 32'h0);
    // back-to-back: second vector offered on the final beat
    idle(1'b1, 32'h44332211);
    beat(1'b0, 32'h0, 1'b1, 8'h44, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h33, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'h22, 1'b0, 1'b0);
    beat(1'b1, 32'hDDCCBBAA, 1'b1, 8'h11, 1'b1, B2B);
    if (!B2B) idle(1'b1, 32'hDDCCBBAA);
    beat(1'b0, 32'h0, 1'b1, 8'hDD, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'hCC, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'hBB, 1'b0, 1'b0);
    beat(1'b0, 32'h0, 1'b1, 8'hAA, 1'b1, B2B);
    idle(1'b0, 32'h0);
  endfunction

  initial begin
    int b0;
    logic seen;
    rst = 1'b1; lv = 1'b0; ld = '0; orr = 1'b0; fill = 8'hEE;
    lv0 = 1'b0; ld0 = '0; or0 = 1'b0;
    build_table();
    repeat (2) @(negedge clk);

    // table-driven vectors on the NUM=3 instance
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; lv = tbl[i].lv; ld = tbl[i].ld; orr = tbl[i].orr;
      #1;
      chk($sformatf("row%0d out_valid", i), {31'b0, ov}, {31'b0, tbl[i].ev});
      chk($sformatf("row%0d out_last", i), {31'b0, last}, {31'b0, tbl[i].el});
      chk($sformatf("row%0d load_ready", i), {31'b0, lr}, {31'b0, tbl[i].elr});
      if (tbl[i].co) chk($sformatf("row%0d out", i), {24'b0, out}, {24'b0, tbl[i].eo});
    end
    @(negedge clk);
    rst = 1'b0; lv = 1'b0; orr = 1'b1;

    // NUM=0: single beat with out_last, load_ready low while pending
    lv0 = 1'b1; ld0 = 8'h5A; or0 = 1'b0;
    #1;
    chk("n0 idle load_ready", {31'b0, lr0}, 32'd1);
    chk("n0 idle out_valid", {31'b0, ov0}, 32'd0);
    @(negedge clk);
    lv0 = 1'b1; ld0 = 8'h77; or0 = 1'b0;
    #1;
    chk("n0 beat out", {24'b0, out0}, 32'h5A);
    chk("n0 beat out_valid", {31'b0, ov0}, 32'd1);
    chk("n0 beat out_last", {31'b0, last0}, 32'd1);
    chk("n0 stall load_ready", {31'b0, lr0}, 32'd0);
    @(negedge clk);
    lv0 = 1'b0; or0 = 1'b1;
    #1;
    chk("n0 held out", {24'b0, out0}, 32'h5A);
    chk("n0 held out_last", {31'b0, last0}, 32'd1);
    chk("n0 accept load_ready", {31'b0, lr0}, {31'b0, B2B});
    @(negedge clk);
    or0 = 1'b0;
    #1;
    chk("n0 after out_valid", {31'b0, ov0}, 32'd0);
    chk("n0 after load_ready", {31'b0, lr0}, 32'd1);

    // round trip through the collector with random stalls
    @(negedge clk);
    b0 = beats;
    lv = 1'b1; ld = 32'h44332211; orr = 1'b1;
    #1;
    chk("rt load_ready", {31'b0, lr}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      lv = 1'b0;
      orr = 1'($urandom_range(0, 1));
      #1;
      if (ov && orr && last) seen = 1'b1;
    end
    @(negedge clk);
    orr = 1'b1;
    chk("rt last seen", {31'b0, seen}, 32'd1);
    chk("rt y", y, 32'h44332211);
    chk("rt beats", 32'(beats - b0), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
